// File: rtl/cache_pkg.sv
// cache_pkg: shared line geometry, field positions and fill FSM states for the cache miss path.
package cache_pkg;
    localparam int LINE_W    = 145;
    localparam int TAG_W     = 15;
    localparam int TAG_MSB   = 144;
    localparam int TAG_LSB_L = 130;
    localparam int VALID_BIT = 1;
    localparam int DIRTY_BIT = 0;

    typedef enum logic [1:0] {IDLE, WB, FILL, DONE} fill_state_t;

    // Word k of a line sits above the valid/dirty pair.
    function automatic int slot_base(input logic [1:0] k);
        return 32 * int'(k) + 2;
    endfunction
endpackage

// File: rtl/cache_line_fill_ctrl_if.sv
// cache_line_fill_ctrl_if: cache-side request, memory beat handshake and line return.
// Adds crit_valid/crit_data when CRIT_WORD_FIRST_EN is defined.
interface cache_line_fill_ctrl_if;
    import cache_pkg::*;
    logic              miss_req;
    logic [31:0]       miss_addr;
    logic [LINE_W-1:0] victim_line;
    logic              mem_req;
    logic              mem_we;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;
    logic              busy;
    logic [LINE_W-1:0] line_out;
    logic              fill_done;
`ifdef CRIT_WORD_FIRST_EN
    logic              crit_valid;
    logic [31:0]       crit_data;
`endif

    modport master (
`ifdef CRIT_WORD_FIRST_EN
        output crit_valid, crit_data,
`endif
        output mem_req, mem_we, mem_addr, mem_wdata, busy, line_out, fill_done,
        input  miss_req, miss_addr, victim_line, mem_ack, mem_rdata
    );

    modport slave (
`ifdef CRIT_WORD_FIRST_EN
        input  crit_valid, crit_data,
`endif
        input  mem_req, mem_we, mem_addr, mem_wdata, busy, line_out, fill_done,
        output miss_req, miss_addr, victim_line, mem_ack, mem_rdata
    );
endinterface

// File: rtl/cache_line_fill_ctrl_line_assembler.sv
// line_assembler: collects four fill beats by slot and presents them in cache line format.
module line_assembler
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [1:0]        sel,
    input  logic [31:0]       wdata,
    input  logic [TAG_W-1:0]  tag,
    input  logic              valid,
    input  logic              dirty,
    output logic [LINE_W-1:0] line
);
    logic [127:0] words;

    always_ff @(posedge clk or posedge rst)
        if (rst)
            words <= '0;
        else if (we)
            words[32 * sel +: 32] <= wdata;

    assign line = {tag, words, valid, dirty};
endmodule

// File: rtl/cache_line_fill_ctrl.sv
// cache_line_fill_ctrl: miss handler; writes back a dirty victim, then fetches the 4-word line.
// Optional CRIT_WORD_FIRST_EN: fill starts at the missed word and reports it via crit_valid/crit_data.
module cache_line_fill_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TAG_LSB = 6
) (
    input logic clk,
    input logic rst,
    cache_line_fill_ctrl_if.master bus
);
    fill_state_t state, state_n;
    logic [1:0] beat, beat_n, beat_inc, done_cnt, done_cnt_n, start_idle, start_wb;
    logic [ADDR_W-1:2] addr_q, addr_n;
    logic [LINE_W-1:2] vic_q, vic_n;
    logic [TAG_W-1:0] line_tag, line_tag_n;
    logic line_vld, line_vld_n, req_n, we_n, ack, last, wr_en;
    logic [ADDR_W-1:0] maddr_n;
    logic [DATA_W-1:0] wdata_n;
    logic [LINE_W-1:0] line;

    // The index field is not kept in the line, so write-back addresses carry zeros there.
    function automatic logic [ADDR_W-1:0] wb_addr(input logic [TAG_W-1:0] t, input logic [1:0] b);
        return {11'd0, t, 4'd0, b};
    endfunction

    assign ack = bus.mem_req & bus.mem_ack;
    assign last = done_cnt == 2'd3;
    assign beat_inc = beat + 2'd1;
    assign bus.busy = state != IDLE;
    assign bus.fill_done = state == DONE;
    assign bus.line_out = line;

`ifdef CRIT_WORD_FIRST_EN
    logic [1:0] crit_q;
    assign start_idle = bus.miss_addr[1:0];
    assign start_wb = crit_q;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            crit_q         <= 2'd0;
            bus.crit_valid <= 1'b0;
            bus.crit_data  <= '0;
        end else begin
            if (state == IDLE && bus.miss_req)
                crit_q <= bus.miss_addr[1:0];
            bus.crit_valid <= state == FILL && ack && done_cnt == 2'd0;
            if (state == FILL && ack && done_cnt == 2'd0)
                bus.crit_data <= bus.mem_rdata;
        end
`else
    assign start_idle = 2'd0;
    assign start_wb = 2'd0;
`endif

    always_comb begin
        state_n    = state;
        beat_n     = beat;
        done_cnt_n = done_cnt;
        addr_n     = addr_q;
        vic_n      = vic_q;
        line_tag_n = line_tag;
        line_vld_n = line_vld;
        req_n      = bus.mem_req;
        we_n       = bus.mem_we;
        maddr_n    = bus.mem_addr;
        wdata_n    = bus.mem_wdata;
        wr_en      = 1'b0;
        case (state)
            IDLE: if (bus.miss_req) begin
                addr_n     = bus.miss_addr[ADDR_W-1:2];
                vic_n      = bus.victim_line[LINE_W-1:2];
                req_n      = 1'b1;
                done_cnt_n = 2'd0;
                if (bus.victim_line[VALID_BIT] && bus.victim_line[DIRTY_BIT]) begin
                    state_n = WB;
                    beat_n  = 2'd0;
                    we_n    = 1'b1;
                    maddr_n = wb_addr(bus.victim_line[TAG_MSB:TAG_LSB_L], 2'd0);
                    wdata_n = bus.victim_line[slot_base(2'd0) +: DATA_W];
                end else begin
                    state_n    = FILL;
                    beat_n     = start_idle;
                    we_n       = 1'b0;
                    maddr_n    = {bus.miss_addr[ADDR_W-1:2], start_idle};
                    line_tag_n = bus.miss_addr[TAG_LSB+TAG_W-1:TAG_LSB];
                    line_vld_n = 1'b1;
                end
            end
            WB: if (ack) begin
                done_cnt_n = done_cnt + 2'd1;
                beat_n     = beat_inc;
                if (last) begin
                    state_n    = FILL;
                    beat_n     = start_wb;
                    we_n       = 1'b0;
                    maddr_n    = {addr_q, start_wb};
                    line_tag_n = addr_q[TAG_LSB+TAG_W-1:TAG_LSB];
                    line_vld_n = 1'b1;
                end else begin
                    maddr_n = wb_addr(vic_q[TAG_MSB:TAG_LSB_L], beat_inc);
                    wdata_n = vic_q[slot_base(beat_inc) +: DATA_W];
                end
            end
            FILL: if (ack) begin
                wr_en      = 1'b1;
                done_cnt_n = done_cnt + 2'd1;
                beat_n     = beat_inc;
                if (last) begin
                    state_n = DONE;
                    req_n   = 1'b0;
                end else
                    maddr_n = {addr_q, beat_inc};
            end
            DONE: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state         <= IDLE;
            beat          <= 2'd0;
            done_cnt      <= 2'd0;
            addr_q        <= '0;
            vic_q         <= '0;
            line_tag      <= '0;
            line_vld      <= 1'b0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            state         <= state_n;
            beat          <= beat_n;
            done_cnt      <= done_cnt_n;
            addr_q        <= addr_n;
            vic_q         <= vic_n;
            line_tag      <= line_tag_n;
            line_vld      <= line_vld_n;
            bus.mem_req   <= req_n;
            bus.mem_we    <= we_n;
            bus.mem_addr  <= maddr_n;
            bus.mem_wdata <= wdata_n;
        end

    line_assembler u_asm (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_en),
        .sel   (beat),
        .wdata (bus.mem_rdata),
        .tag   (line_tag),
        .valid (line_vld),
        .dirty (1'b0),
        .line  (line)
    );
endmodule

// File: tb/tb_cache_line_fill_ctrl.sv
// tb_cache_line_fill_ctrl: directed and random misses against a beat-list/line reference model.
// Honours CRIT_WORD_FIRST_EN for fill order and critical-word checks.
module tb_cache_line_fill_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_line_fill_ctrl_if bus();
    cache_line_fill_ctrl dut (.clk(clk), .rst(rst), .bus(bus.master));

    typedef struct packed {logic we; logic [31:0] addr; logic [31:0] data;} beat_t;
    beat_t log_q[$];
    beat_t exp_q[$];
    beat_t st;
    logic [31:0] rword [4];
    int n_checks = 0, n_fail = 0, stall_cfg = 0, wcnt = 0;
    bit stalled = 0, idle_ack_en = 1;
`ifdef CRIT_WORD_FIRST_EN
    int crit_pulses = 0;
    logic [31:0] crit_d = '0;
    always @(negedge clk)
        if (bus.crit_valid) begin
            crit_pulses++;
            crit_d = bus.crit_data;
        end
`endif

    task automatic chk(input string tag, input logic [144:0] obs, input logic [144:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory model: stalls stall_cfg cycles before each beat, serves rword by word offset.
    always @(negedge clk) begin
        if (rst) begin
            bus.mem_ack = 1'b0;
            wcnt = 0;
            stalled = 0;
        end else begin
            if (stalled)
                chk("stall_hold", {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata}, {1'b1, st.we, st.addr, st.data});
            bus.mem_rdata = $urandom;
            if (bus.mem_req && wcnt >= stall_cfg) begin
                bus.mem_ack = 1'b1;
                wcnt = 0;
                stalled = 0;
                log_q.push_back('{bus.mem_we, bus.mem_addr, bus.mem_wdata});
                bus.mem_rdata = rword[bus.mem_addr[1:0]];
            end else if (bus.mem_req) begin
                bus.mem_ack = 1'b0;
                wcnt++;
                stalled = 1;
                st = '{bus.mem_we, bus.mem_addr, bus.mem_wdata};
            end else begin
                bus.mem_ack = idle_ack_en && $urandom_range(1, 0) == 1;
                wcnt = 0;
                stalled = 0;
            end
        end
    end

    task automatic run_txn(input string name, input logic [31:0] addr, input logic [144:0] vic, input int stall, input bit poke);
        int k, nb, s;
        logic [144:0] exp_line;
        beat_t ob;
        stall_cfg = stall;
        log_q.delete();
        exp_q.delete();
        if (vic[1] && vic[0])
            for (int i = 0; i < 4; i++)
                exp_q.push_back('{1'b1, 32'(vic[144:130]) * 64 + 32'(i), 32'(vic >> (32 * i + 2))});
`ifdef CRIT_WORD_FIRST_EN
        s = int'(addr[1:0]);
        crit_pulses = 0;
`else
        s = 0;
`endif
        for (int i = 0; i < 4; i++)
            exp_q.push_back('{1'b0, (addr & ~32'h3) + 32'((s + i) % 4), 32'h0});
        exp_line = {addr[20:6], rword[3], rword[2], rword[1], rword[0], 2'b10};
        nb = exp_q.size();
        bus.miss_req = 1'b1;
        bus.miss_addr = addr;
        bus.victim_line = vic;
        @(posedge clk);
        @(negedge clk);
        bus.miss_req = 1'b0;
        bus.miss_addr = $urandom;
        bus.victim_line = 145'({$urandom, $urandom, $urandom, $urandom, $urandom});
        chk({name, "_busy"}, bus.busy, 1);
        k = 0;
        while (!bus.fill_done && k < 400) begin
            if (poke)
                bus.miss_req = k == 1;
            @(posedge clk);
            k++;
            @(negedge clk);
        end
        bus.miss_req = 1'b0;
        chk({name, "_cycles"}, k, nb * (1 + stall));
        chk({name, "_line"}, bus.line_out, exp_line);
        chk({name, "_nbeats"}, log_q.size(), nb);
        for (int i = 0; i < nb && i < log_q.size(); i++) begin
            ob = log_q[i];
            if (!ob.we)
                ob.data = 32'h0;
            chk($sformatf("%s_beat%0d", name, i), ob, exp_q[i]);
        end
`ifdef CRIT_WORD_FIRST_EN
        chk({name, "_crit_pulses"}, crit_pulses, 1);
        chk({name, "_crit_data"}, crit_d, rword[s]);
`endif
        if (poke) begin
            bus.miss_req = 1'b1;
            bus.miss_addr = addr ^ 32'h100;
        end
        @(posedge clk);
        @(negedge clk);
        bus.miss_req = 1'b0;
        chk({name, "_idle"}, {bus.busy, bus.fill_done, bus.mem_req}, 0);
        chk({name, "_hold"}, bus.line_out, exp_line);
        if (poke) begin
            @(posedge clk);
            @(negedge clk);
            chk({name, "_no_second"}, {bus.busy, 32'(log_q.size())}, {1'b0, 32'(nb)});
        end
    endtask

    initial begin
        logic [144:0] vic;
        logic [31:0] a;
        bus.miss_req = 1'b0;
        bus.miss_addr = '0;
        bus.victim_line = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_line_out", bus.line_out, 0);
        chk("rst_fill_done", bus.fill_done, 0);
`ifdef CRIT_WORD_FIRST_EN
        chk("rst_crit", {bus.crit_valid, bus.crit_data}, 0);
`endif
        rst = 1'b0;
        @(negedge clk);

        rword = '{32'h11, 32'h22, 32'h33, 32'h44};
        run_txn("clean", 32'h48, 145'h0, 0, 0);
        chk("clean_line_const", bus.line_out, {15'h1, 32'h44, 32'h33, 32'h22, 32'h11, 2'b10});

        for (int i = 0; i < 4; i++) rword[i] = $urandom;
        run_txn("dirty", $urandom, {15'h7, 32'hA3, 32'hA2, 32'hA1, 32'hA0, 2'b11}, 0, 0);

        for (int i = 0; i < 4; i++) rword[i] = $urandom;
        run_txn("stall_clean", $urandom, 145'h2, 3, 0);
        for (int i = 0; i < 4; i++) rword[i] = $urandom;
        vic = 145'({$urandom, $urandom, $urandom, $urandom, $urandom}) | 145'h3;
        run_txn("stall_dirty", $urandom, vic, 3, 0);

        vic = 145'({$urandom, $urandom, $urandom, $urandom, $urandom}) & ~145'h2;
        run_txn("dirty_not_valid", $urandom, vic, 0, 0);
        run_txn("ignore", $urandom, 145'h0, 1, 1);
        rword = '{32'hC0, 32'hC1, 32'hC2, 32'hC3};
        run_txn("crit2", 32'h0000_004A, 145'h0, 0, 0);

        // Reset after the second write-back ack.
        stall_cfg = 0;
        vic = 145'({$urandom, $urandom, $urandom, $urandom, $urandom}) | 145'h3;
        bus.miss_req = 1'b1;
        bus.miss_addr = $urandom;
        bus.victim_line = vic;
        @(posedge clk);
        @(negedge clk);
        bus.miss_req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("mid_wb_beat2", {bus.mem_req, bus.mem_we, bus.mem_addr}, {2'b11, 32'(vic[144:130]) * 64 + 32'd2});
        rst = 1'b1;
        #1;
        chk("mid_rst_outs", {bus.busy, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.fill_done}, 0);
        chk("mid_rst_line", bus.line_out, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) rword[i] = $urandom;
        run_txn("after_rst", $urandom, 145'h1, 0, 0);

        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < 4; i++) rword[i] = $urandom;
            idle_ack_en = $urandom_range(1, 0) == 1;
            a = $urandom;
            vic = 145'({$urandom, $urandom, $urandom, $urandom, $urandom});
            run_txn($sformatf("rnd%0d", n), a, vic, int'($urandom_range(2, 0)), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
